// File: rtl/instr_fetch_pkg.sv
// Shared constants for the fetch stage and the decoder it feeds.
package instr_fetch_pkg;

  // Fetch FSM state encoding; the numeric values appear on test_state.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_B0   = 3'd2,
    S_B1   = 3'd3,
    S_B2   = 3'd4,
    S_B3   = 3'd5,
    S_EXEC = 3'd6,
    S_SYNC = 3'd7
  } fetch_state_e;

  localparam int PC_STEP_DEFAULT = 4;
  localparam int INSTR_W         = 32;
  localparam int BYTE_W          = 8;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage, instruction memory, PC register and decoder.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]  IMemory_raddr;
  logic [BYTE_W-1:0]  IMemory_rdata;
  logic [ADDR_W-1:0]  PC_rdata;
  logic [ADDR_W-1:0]  PC_fetch_wdata;
  logic               PC_fetch_wren;
  logic               PC_decode_wren;
  logic [INSTR_W-1:0] instr;
  logic               run;
  logic               ok;
  logic               intr;

  // Fetch-stage view.
  modport master (
    output IMemory_raddr, PC_fetch_wdata, PC_fetch_wren, instr, run,
    input  IMemory_rdata, PC_rdata, PC_decode_wren, ok, intr
  );

  // Memory / PC / decoder view.
  modport slave (
    input  IMemory_raddr, PC_fetch_wdata, PC_fetch_wren, instr, run,
    output IMemory_rdata, PC_rdata, PC_decode_wren, ok, intr
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles a 32-bit word from four byte reads, hands it to
// the decoder, then advances the PC unless the decoder redirected it.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_STEP = PC_STEP_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  instr_fetch_if.master bus,
  output logic [31:0] instr_count,
  output logic [2:0]  test_state
);

  fetch_state_e       r_state;
  fetch_state_e       w_next;
  logic [ADDR_W-1:0]  r_raddr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_wdata;
  logic               r_wren;
  logic               r_run;
  logic [31:0]        r_count;
  logic               r_redirect;
  logic               r_stopped;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!halt && !r_stopped) w_next = S_ADDR;
      S_ADDR:  w_next = halt ? S_IDLE : S_B0;
      S_B0:    w_next = S_B1;
      S_B1:    w_next = S_B2;
      S_B2:    w_next = S_B3;
      S_B3:    w_next = S_EXEC;
      S_EXEC:  if (bus.ok) w_next = S_SYNC;
      S_SYNC:  w_next = (r_stopped || halt) ? S_IDLE : S_ADDR;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, decoder handshake, PC update and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr    <= '0;
      r_instr    <= '0;
      r_wdata    <= '0;
      r_wren     <= 1'b0;
      r_run      <= 1'b0;
      r_count    <= '0;
      r_redirect <= 1'b0;
      r_stopped  <= 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          r_raddr    <= bus.PC_rdata;
          r_redirect <= 1'b0;
        end
        S_B0: begin
          r_instr[7:0] <= bus.IMemory_rdata;
          r_raddr      <= r_raddr + 1'b1;
        end
        S_B1: begin
          r_instr[15:8] <= bus.IMemory_rdata;
          r_raddr       <= r_raddr + 1'b1;
        end
        S_B2: begin
          r_instr[23:16] <= bus.IMemory_rdata;
          r_raddr        <= r_raddr + 1'b1;
        end
        S_B3: begin
          r_instr[31:24] <= bus.IMemory_rdata;
          r_run          <= 1'b1;
        end
        S_EXEC: begin
          if (bus.PC_decode_wren) r_redirect <= 1'b1;
          if (bus.ok) begin
            r_run   <= 1'b0;
            r_count <= r_count + 1'b1;
            // A decoder PC write in the same cycle as ok still counts as a redirect.
            if (!r_redirect && !bus.PC_decode_wren) begin
              r_wdata <= bus.PC_rdata + ADDR_W'(PC_STEP);
              r_wren  <= 1'b1;
            end
            if (bus.intr) r_stopped <= 1'b1;
          end
        end
        S_SYNC: r_wren <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.IMemory_raddr  = r_raddr;
  assign bus.instr          = r_instr;
  assign bus.PC_fetch_wdata = r_wdata;
  assign bus.PC_fetch_wren  = r_wren;
  assign bus.run            = r_run;
  assign instr_count        = r_count;
  assign test_state         = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a byte memory and a PC register model;
// the decoder handshake is driven step by step from the stimulus sequence.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [31:0] instr_count;
  logic [2:0]  test_state;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .halt        (halt),
    .bus         (bus),
    .instr_count (instr_count),
    .test_state  (test_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wren_cnt = 0;

  logic [7:0]  mem [256];
  logic [31:0] pc;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] dec_target;
  int          wren_snap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational byte memory, low 8 address bits only.
  assign bus.IMemory_rdata = mem[bus.IMemory_raddr[7:0]];
  assign bus.PC_rdata      = pc;

  // PC register: bench load, decoder write, then fetch write.
  always @(posedge clk) begin
    if (pc_load)                 pc <= pc_load_val;
    else if (bus.PC_decode_wren) pc <= dec_target;
    else if (bus.PC_fetch_wren)  pc <= bus.PC_fetch_wdata;
  end

  // Count PC write strobe cycles.
  always @(posedge clk) begin
    if (bus.PC_fetch_wren) wren_cnt <= wren_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_run"},   32'(bus.run), 32'd0);
    check({tag, "_wren"},  32'(bus.PC_fetch_wren), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_count"}, instr_count, 32'd0);
    check({tag, "_state"}, 32'(test_state), 32'd0);
    check({tag, "_raddr"}, bus.IMemory_raddr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]} = {8'h78, 8'h56, 8'h34, 8'h12};
    {mem[8'h04], mem[8'h05], mem[8'h06], mem[8'h07]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} = {8'h0D, 8'hF0, 8'hAD, 8'h0B};
    {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]} = {8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; halt = 1'b0;
    bus.ok = 1'b0; bus.intr = 1'b0; bus.PC_decode_wren = 1'b0;
    dec_target = '0; pc_load = 1'b1; pc_load_val = 32'h0;
    step(2);
    check_reset_state("reset");
    check("reset_wdata", bus.PC_fetch_wdata, 32'd0);
    rst = 1'b0; pc_load = 1'b0;

    // Sequential fetch from PC=0.
    step(1); check("seq_state_addr", 32'(test_state), 32'd1);
    step(1); check("seq_raddr0", bus.IMemory_raddr, 32'h0);
    step(3); check("seq_raddr3", bus.IMemory_raddr, 32'h3);
    check("seq_run_early", 32'(bus.run), 32'd0);
    step(1);
    check("seq_run", 32'(bus.run), 32'd1);
    check("seq_instr", bus.instr, 32'h12345678);
    check("seq_state_exec", 32'(test_state), 32'd6);
    step(4);
    check("seq_run_held", 32'(bus.run), 32'd1);
    check("seq_instr_held", bus.instr, 32'h12345678);
    bus.ok = 1'b1;
    step(1);
    bus.ok = 1'b0;
    check("seq_run_drop", 32'(bus.run), 32'd0);
    check("seq_wren", 32'(bus.PC_fetch_wren), 32'd1);
    check("seq_wdata", bus.PC_fetch_wdata, 32'h4);
    check("seq_count", instr_count, 32'd1);
    check("seq_state_sync", 32'(test_state), 32'd7);
    step(1);
    check("seq_wren_pulse", 32'(bus.PC_fetch_wren), 32'd0);
    check("seq_state_addr2", 32'(test_state), 32'd1);
    step(1); check("seq_next_raddr", bus.IMemory_raddr, 32'h4);

    // Redirect: decoder writes PC one cycle before ok.
    step(4);
    check("redir_instr", bus.instr, 32'hDEADBEEF);
    step(2);
    bus.PC_decode_wren = 1'b1; dec_target = 32'h40;
    step(1);
    bus.PC_decode_wren = 1'b0; bus.ok = 1'b1;
    wren_snap = wren_cnt;
    step(1);
    bus.ok = 1'b0;
    check("redir_wren", 32'(bus.PC_fetch_wren), 32'd0);
    check("redir_count", instr_count, 32'd2);
    step(2);
    check("redir_raddr", bus.IMemory_raddr, 32'h40);
    check("redir_no_strobe", 32'(wren_cnt - wren_snap), 32'd0);
    check("redir_wdata_kept", bus.PC_fetch_wdata, 32'h4);

    // Simultaneous decoder PC write and ok; target sets up the wrap test.
    step(4);
    check("sim_instr", bus.instr, 32'h0BADF00D);
    bus.PC_decode_wren = 1'b1; dec_target = 32'hFFFF_FFFC; bus.ok = 1'b1;
    wren_snap = wren_cnt;
    step(1);
    bus.PC_decode_wren = 1'b0; bus.ok = 1'b0;
    check("sim_wren", 32'(bus.PC_fetch_wren), 32'd0);
    step(1);
    check("sim_no_strobe", 32'(wren_cnt - wren_snap), 32'd0);

    // Wrap-around at the top of the address space.
    step(1); check("wrap_raddr0", bus.IMemory_raddr, 32'hFFFF_FFFC);
    step(1); check("wrap_raddr1", bus.IMemory_raddr, 32'hFFFF_FFFD);
    step(1); check("wrap_raddr2", bus.IMemory_raddr, 32'hFFFF_FFFE);
    step(1); check("wrap_raddr3", bus.IMemory_raddr, 32'hFFFF_FFFF);
    step(1); check("wrap_instr", bus.instr, 32'h44332211);
    bus.ok = 1'b1;
    step(1);
    bus.ok = 1'b0;
    check("wrap_wren", 32'(bus.PC_fetch_wren), 32'd1);
    check("wrap_wdata", bus.PC_fetch_wdata, 32'h0);
    check("wrap_count", instr_count, 32'd4);

    // Halt raised during EXEC: PC update still happens, then IDLE.
    step(6);
    check("halt_instr", bus.instr, 32'h12345678);
    halt = 1'b1;
    step(1);
    bus.ok = 1'b1;
    step(1);
    bus.ok = 1'b0;
    check("halt_wren", 32'(bus.PC_fetch_wren), 32'd1);
    check("halt_wdata", bus.PC_fetch_wdata, 32'h4);
    step(1);
    check("halt_idle", 32'(test_state), 32'd0);
    step(3);
    check("halt_stay_idle", 32'(test_state), 32'd0);
    halt = 1'b0;
    step(1);
    check("halt_release", 32'(test_state), 32'd1);

    // Exception with ok: retire once, then stay stopped.
    step(5);
    check("intr_instr", bus.instr, 32'hDEADBEEF);
    bus.ok = 1'b1; bus.intr = 1'b1;
    step(1);
    bus.ok = 1'b0; bus.intr = 1'b0;
    check("intr_count", instr_count, 32'd6);
    step(6);
    check("intr_idle", 32'(test_state), 32'd0);
    check("intr_run", 32'(bus.run), 32'd0);
    check("intr_count_once", instr_count, 32'd6);

    // Reset during B2.
    rst = 1'b1; pc_load = 1'b1; pc_load_val = 32'h0;
    step(1);
    rst = 1'b0; pc_load = 1'b0;
    step(4);
    check("rstb2_state", 32'(test_state), 32'd4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_state("rst_b2");

    // Reset during EXEC; stopped must also have cleared.
    step(6);
    check("rstex_run", 32'(bus.run), 32'd1);
    check("rstex_state", 32'(test_state), 32'd6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_state("rst_exec");
    step(1);
    check("rst_restart", 32'(test_state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
